// File: rtl/tt_um_spi_responder.sv
// SPI mode-0 responder exposing an 8x8-bit register file over 16-bit frames.
// SCLK/CS_N/MOSI are oversampled by clk; registers 6 and 7 drive uio_out/uio_oe.
module tt_um_spi_responder #(
    parameter logic [7:0]  ID_VALUE    = 8'hA5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_t;

    // Synchroniser chains and edge-detect history
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    // Frame state
    state_t      r_state, w_state_d;
    logic [2:0]  r_cnt, w_cnt_d;
    logic [7:0]  r_shift, w_shift_d;
    logic [7:0]  r_out, w_out_d;
    logic        r_miso, w_miso_d;
    logic        r_w, w_w_d;
    logic [6:0]  r_addr, w_addr_d;
    logic        r_abort, w_abort_d;
    logic        r_last_read, w_last_read_d;
    logic [3:0]  r_wcnt, w_wcnt_d;
    logic        w_we;
    logic [7:0]  w_byte;
    logic [7:0]  r_regs [8];

    logic w_busy, w_miso;
    logic w_unused;

    assign w_unused = &{1'b0, uio_in, ui_in[7:3]};

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev;

    // Byte as it stands after the current rising-edge sample
    assign w_byte = {r_shift[6:0], w_mosi_s};

    // Read data for an address: out-of-range reads 0, reg0 is the fixed ID
    function automatic logic [7:0] f_read(input logic [6:0] a);
        if (a[6:3] != 4'd0) begin
            return 8'h00;
        end else if (a[2:0] == 3'd0) begin
            return ID_VALUE;
        end else begin
            return r_regs[a[2:0]];
        end
    endfunction

    // Synchronise SPI pins and keep one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ui_in[0]};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], ui_in[1]};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], ui_in[2]};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    // Next-state and datapath updates for the frame FSM
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_shift_d     = r_shift;
        w_out_d       = r_out;
        w_miso_d      = r_miso;
        w_w_d         = r_w;
        w_addr_d      = r_addr;
        w_abort_d     = r_abort;
        w_last_read_d = r_last_read;
        w_wcnt_d      = r_wcnt;
        w_we          = 1'b0;

        if (!ena) begin
            // Drop any frame silently; no abort is flagged
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_cs_fall) begin
                        w_state_d = StCmd;
                        w_cnt_d   = 3'd0;
                        w_miso_d  = 1'b0;
                    end
                end
                StCmd: begin
                    if (w_cs_rise) begin
                        w_state_d = StIdle;
                        w_abort_d = 1'b1;
                    end else if (w_sclk_rise) begin
                        w_shift_d = w_byte;
                        w_cnt_d   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_w_d     = w_byte[7];
                            w_addr_d  = w_byte[6:0];
                            w_out_d   = w_byte[7] ? 8'h00 : f_read(w_byte[6:0]);
                            w_miso_d  = 1'b0;
                            w_state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (w_sclk_rise && r_cnt == 3'd7) begin
                        // Completion beats a coincident CS_N rise
                        if (r_w) begin
                            if (r_addr[6:3] == 4'd0 && r_addr[2:0] != 3'd0) begin
                                w_we      = 1'b1;
                                w_wcnt_d  = r_wcnt + 4'd1;
                                w_abort_d = 1'b0;
                            end
                        end else begin
                            w_abort_d = 1'b0;
                        end
                        w_last_read_d = ~r_w;
                        w_shift_d     = w_byte;
                        w_cnt_d       = 3'd0;
                        w_miso_d      = 1'b0;
                        w_state_d     = w_cs_rise ? StIdle : StDone;
                    end else if (w_cs_rise) begin
                        w_state_d = StIdle;
                        w_abort_d = 1'b1;
                    end else begin
                        if (w_sclk_rise) begin
                            w_shift_d = w_byte;
                            w_cnt_d   = r_cnt + 3'd1;
                        end
                        if (w_sclk_fall) begin
                            w_miso_d = r_out[7];
                            w_out_d  = {r_out[6:0], 1'b0};
                        end
                    end
                end
                StDone: begin
                    if (w_cs_rise) begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Frame state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_shift     <= 8'h00;
            r_out       <= 8'h00;
            r_miso      <= 1'b0;
            r_w         <= 1'b0;
            r_addr      <= 7'd0;
            r_abort     <= 1'b0;
            r_last_read <= 1'b0;
            r_wcnt      <= 4'd0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_shift     <= w_shift_d;
            r_out       <= w_out_d;
            r_miso      <= w_miso_d;
            r_w         <= w_w_d;
            r_addr      <= w_addr_d;
            r_abort     <= w_abort_d;
            r_last_read <= w_last_read_d;
            r_wcnt      <= w_wcnt_d;
        end
    end

    // Register file; slot 0 holds the ID and is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs[0] <= ID_VALUE;
            for (int i = 1; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_we) begin
            r_regs[r_addr[2:0]] <= w_byte;
        end
    end

    assign w_busy  = (r_state != StIdle);
    assign w_miso  = (r_state == StData) & ~w_cs_s & r_miso;
    assign uo_out  = {r_wcnt, w_busy, r_last_read, r_abort, w_miso};
    assign uio_out = r_regs[6];
    assign uio_oe  = r_regs[7];

endmodule

// File: tb/tb_tt_um_spi_responder.sv
// Randomised SPI frame bench for tt_um_spi_responder with a register-level reference model.
module tb_tt_um_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {5'b0, mosi, cs_n, sclk};

    tt_um_spi_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_regs [8];
    int         m_wcnt;
    logic       m_abort;
    logic       m_last_read;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_regs[0] = 8'hA5;
        for (int i = 1; i < 8; i++) m_regs[i] = 8'h00;
        m_wcnt      = 0;
        m_abort     = 1'b0;
        m_last_read = 1'b0;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a > 7'd7) return 8'h00;
        return m_regs[a];
    endfunction

    function automatic logic [7:0] exp_uo();
        return {m_wcnt[3:0], 1'b0, m_last_read, m_abort, 1'b0};
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame of nbits SCLK pulses; ena goes low before bit ena_off and back at ena_on
    task automatic spi_frame(input logic w, input logic [6:0] addr, input logic [7:0] data,
                             input int nbits, input int ena_off, input int ena_on,
                             output logic [15:0] rx);
        logic [15:0] word;
        word = {w, addr, data};
        rx = 16'h0;
        cs_n = 1'b0;
        clks(8);
        check("busy_mid_frame", {31'b0, uo_out[3]}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == ena_off) ena = 1'b0;
            if (i == ena_on) ena = 1'b1;
            mosi = (i < 16) ? word[15-i] : 1'b1;
            clks(8);
            if (i < 16) rx = {rx[14:0], uo_out[0]};
            sclk = 1'b1;
            clks(8);
            sclk = 1'b0;
        end
        ena = 1'b1;
        clks(8);
        cs_n = 1'b1;
        clks(8);
    endtask

    // Run a frame, update the model and compare all visible outputs
    task automatic do_frame(input logic w, input logic [6:0] addr, input logic [7:0] data,
                            input int nbits);
        logic [15:0] rx;
        spi_frame(w, addr, data, nbits, -1, -1, rx);
        if (nbits >= 16) begin
            if (w) begin
                if (addr != 7'd0 && addr < 7'd8) begin
                    m_regs[addr] = data;
                    m_wcnt = (m_wcnt + 1) % 16;
                    m_abort = 1'b0;
                end
            end else begin
                check("read_data", {16'h0, rx}, {16'h0, 8'h00, model_read(addr)});
                m_abort = 1'b0;
            end
            m_last_read = ~w;
        end else begin
            m_abort = 1'b1;
        end
        check("uo_out", {24'h0, uo_out}, {24'h0, exp_uo()});
        check("uio_out", {24'h0, uio_out}, {24'h0, m_regs[6]});
        check("uio_oe", {24'h0, uio_oe}, {24'h0, m_regs[7]});
    endtask

    initial begin
        logic [15:0] rx;
        model_reset();
        clks(3);
        rst_n = 1'b1;
        clks(3);
        check("reset_uo_out", {24'h0, uo_out}, 32'h0);
        check("reset_uio_out", {24'h0, uio_out}, 32'h0);
        check("reset_uio_oe", {24'h0, uio_oe}, 32'h0);

        // ID read, pin-configuration writes and read-back
        do_frame(1'b0, 7'd0, 8'h00, 16);
        do_frame(1'b1, 7'd6, 8'h3C, 16);
        do_frame(1'b1, 7'd7, 8'hFF, 16);
        do_frame(1'b0, 7'd6, 8'h00, 16);

        // Writes to read-only and out-of-range addresses
        do_frame(1'b1, 7'd0, 8'h55, 16);
        do_frame(1'b1, 7'd9, 8'h77, 16);
        do_frame(1'b0, 7'd0, 8'h00, 16);
        do_frame(1'b0, 7'd9, 8'h00, 16);

        // Abort after 11 bits, then a completed frame clears the flag
        do_frame(1'b1, 7'd1, 8'h12, 11);
        do_frame(1'b0, 7'd1, 8'h00, 16);

        // Over-long frame
        do_frame(1'b1, 7'd2, 8'h81, 20);
        do_frame(1'b0, 7'd2, 8'h00, 16);

        // ena dropped mid-frame: frame discarded, no abort
        spi_frame(1'b1, 7'd3, 8'h99, 16, 6, 9, rx);
        check("ena_drop_uo_out", {24'h0, uo_out}, {24'h0, exp_uo()});
        do_frame(1'b0, 7'd3, 8'h00, 16);

        // Asynchronous reset mid-frame
        cs_n = 1'b0;
        mosi = 1'b1;
        clks(8);
        sclk = 1'b1;
        clks(8);
        sclk = 1'b0;
        clks(4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_uio_out", {24'h0, uio_out}, 32'h0);
        check("async_rst_uo_out", {24'h0, uo_out}, 32'h0);
        model_reset();
        cs_n = 1'b1;
        mosi = 1'b0;
        clks(4);
        rst_n = 1'b1;
        clks(8);

        // Sixteen counted writes wrap the counter back to zero
        for (int i = 0; i < 16; i++) begin
            do_frame(1'b1, 7'($urandom_range(1, 7)), 8'($urandom), 16);
        end
        check("wcnt_wrap", {28'h0, uo_out[7:4]}, 32'h0);

        // Randomised mix of reads, writes, aborts and long frames
        for (int i = 0; i < 120; i++) begin
            logic       w;
            logic [6:0] a;
            int         nb;
            int         r;
            w = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r == 0) nb = $urandom_range(0, 15);
            else if (r == 1) nb = 16 + $urandom_range(1, 6);
            else nb = 16;
            do_frame(w, a, 8'($urandom), nb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_spi_responder.md
Name: tt_um_spi_responder

Overview:
- Tiny Tapeout user project implementing an SPI mode-0 responder (slave) on the standard TT pinout.
- Exposes an 8x8-bit register file over 16-bit SPI frames: the bench or an external initiator drives SCLK/CS_N/MOSI on ui_in, and the block returns MISO on uo_out.
- Registers 6 and 7 drive the bidirectional pins, so the design's own outputs can be configured over SPI.
- SPI pins are oversampled by clk; clk must be at least 8x the SCLK frequency.

Parameters:
- ID_VALUE, 8'hA5, read-only contents of register 0
- SYNC_STAGES, 2, synchroniser depth on ui_in[2:0] (minimum 2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design selected; 0 = hold FSM in IDLE, registers retained
- ui_in  input  8  [0]=SCLK, [1]=CS_N, [2]=MOSI, [7:3] unused
- uo_out  output  8  [0]=MISO, [1]=abort flag, [2]=last frame was read, [3]=busy, [7:4]=completed-write count mod 16
- uio_in  input  8  unused
- uio_out  output  8  register 6
- uio_oe  output  8  register 7

Behaviour:
- Reset (async, rst_n=0):
  - reg0 = ID_VALUE; reg1..reg7 = 0.
  - FSM = IDLE; uo_out = 0; uio_out = 0; uio_oe = 0.
  - Synchronisers and shift registers cleared; synchronised SCLK resets to 0 and CS_N to 1.
- Input path:
  - SCLK, CS_N and MOSI each pass through SYNC_STAGES flops, then one edge-detect register.
  - Pin-to-event latency is 3 clk with the default depth.
  - MOSI is sampled on the synchronised SCLK rising edge; MISO is updated on the falling edge.
- Frame format (MSB first, 16 bits):
  - bit15 = W (1 = write, 0 = read); bits14:8 = addr[6:0]; bits7:0 = data.
- FSM:
  - IDLE -> CMD on the synchronised CS_N falling edge; bit counter cleared.
  - CMD: shift 8 bits. On the 8th rising edge, latch W and addr. For a read, load the output shift register with the read data; MISO presents bit7 on the following falling edge. Then -> DATA.
  - DATA: shift 8 bits. On the 16th rising edge, if W=1 and the address is writable, commit data, increment the write count (wraps 15 -> 0) and clear the abort flag. A completed read also clears the abort flag. uo_out[2] = !W. Then -> DONE.
  - DONE: ignore further SCLK edges; -> IDLE on the CS_N rising edge.
  - CS_N rising in CMD or DATA: -> IDLE, no write, abort flag (uo_out[1]) set and sticky until the next completed frame.
- Address rules:
  - addr[6:3] != 0: write ignored (count not incremented), read returns 8'h00.
  - addr 0: read returns ID_VALUE; writes ignored and not counted.
  - Registers 1-7 are read/write.
- MISO:
  - 0 whenever CS_N is high, in CMD, and in DONE.
  - Driven from the output shift register only in DATA.
- Busy (uo_out[3]) = 1 whenever FSM != IDLE.
- ena=0:
  - FSM forced to IDLE with no abort flagged; registers and outputs hold.
  - A frame already in progress is dropped silently.
- SCLK edges while CS_N is high are ignored.
- Simultaneous CS_N rise and the 16th SCLK rise in the same synchronised cycle: the commit wins, then -> IDLE with no abort.
- Register 6/7 writes reach uio_out/uio_oe on the clk after the commit.

Test Plan:
- After reset, uo_out=0x00, uio_out=0x00 and uio_oe=0x00; read addr 0 -> MISO shifts 0xA5, uo_out[2]=1.
- Write 0x3C to addr 6, then 0xFF to addr 7 -> uio_out=0x3C, uio_oe=0xFF, uo_out[7:4]=2; read addr 6 returns 0x3C.
- Write 0x55 to addr 0 and 0x77 to addr 9 -> reg0 is still 0xA5, a read of addr 9 returns 0x00, and the write count is unchanged.
- Raise CS_N after 11 bits of a write 0x12 to addr 1 -> reg1 stays 0, uo_out[1]=1, busy=0; the next completed frame clears uo_out[1].
- Send 20 SCLK pulses in one frame writing 0x81 to addr 2 -> reg2=0x81, extra bits ignored, count +1; complete 16 writes from reset -> count wraps to 0.
- Pulse rst_n low mid-frame after 0x3C was written to reg6 -> uio_out=0x00 immediately (async); drop ena mid-frame -> no write and no abort flag.
